// File: rtl/io_scan_port_if.sv
// BRAM port-B bundle shared between io_scan_port (master) and the block RAM (slave).
interface io_scan_port_if;
  logic [15:0] addr_b;
  logic [15:0] data_b;
  logic        we_b;
  logic [15:0] q_b;

  modport master (
    output addr_b,
    output data_b,
    output we_b,
    input  q_b
  );

  modport slave (
    input  addr_b,
    input  data_b,
    input  we_b,
    output q_b
  );
endinterface

// File: rtl/io_scan_port.sv
// Once-per-frame peripheral mailbox scan on BRAM port B: write buttons, read four state words and
// publish them as an atomic snapshot. Define IO_DEBOUNCE_EN to debounce the button word.
module io_scan_port #(
  parameter logic [15:0] IO_BASE   = 16'h0F00,
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_start,
  input  logic [3:0]     btn_raw,
  io_scan_port_if.master bram,
  output logic [15:0]    ball_x,
  output logic [15:0]    ball_y,
  output logic [15:0]    pad_l,
  output logic [15:0]    pad_r,
  output logic           frame_valid,
  output logic           busy,
  output logic           overrun
);

  typedef enum logic [2:0] {
    StIdle, StWrite, StRd0, StRd1, StRd2, StRd3, StWait, StCommit
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  sync1_q, btn_s_q, btn_w;
  logic [15:0] shadow_q [4];
  logic [15:0] snap_q   [4];
  logic        frame_valid_q, overrun_q;
  logic [15:0] addr_d, data_d;
  logic        we_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      btn_s_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      btn_s_q <= sync1_q;
    end
  end

`ifdef IO_DEBOUNCE_EN
  logic [15:0] db_cnt_q [4];
  logic [3:0]  btn_db_q;

  // A bit follows btn_s only once it has differed from btn_db for DB_CYCLES cycles in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_db_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (btn_s_q[i] == btn_db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_CYCLES - 16'd1) begin
          btn_db_q[i] <= btn_s_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign btn_w = btn_db_q;
`else
  logic unused_db_cycles;
  assign unused_db_cycles = ^DB_CYCLES;
  assign btn_w = btn_s_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = IO_BASE;
    data_d  = '0;
    we_d    = 1'b0;
    unique case (state_q)
      StIdle:   if (frame_start) state_d = StWrite;
      StWrite: begin
        we_d    = 1'b1;
        data_d  = {12'b0, btn_w};
        state_d = StRd0;
      end
      StRd0: begin
        addr_d  = IO_BASE + 16'd1;
        state_d = StRd1;
      end
      StRd1: begin
        addr_d  = IO_BASE + 16'd2;
        state_d = StRd2;
      end
      StRd2: begin
        addr_d  = IO_BASE + 16'd3;
        state_d = StRd3;
      end
      StRd3: begin
        addr_d  = IO_BASE + 16'd4;
        state_d = StWait;
      end
      StWait:   state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // q_b lags the address by one cycle, so each word is captured one state after its read.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= '0;
        snap_q[i]   <= '0;
      end
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      case (state_q)
        StRd1:    shadow_q[0] <= bram.q_b;
        StRd2:    shadow_q[1] <= bram.q_b;
        StRd3:    shadow_q[2] <= bram.q_b;
        StWait:   shadow_q[3] <= bram.q_b;
        StCommit: for (int i = 0; i < 4; i++) snap_q[i] <= shadow_q[i];
        default:  ;
      endcase
      frame_valid_q <= (state_q == StCommit);
      if (frame_start && (state_q != StIdle)) overrun_q <= 1'b1;
    end
  end

  assign bram.addr_b = addr_d;
  assign bram.data_b = data_d;
  assign bram.we_b   = we_d;
  assign ball_x      = snap_q[0];
  assign ball_y      = snap_q[1];
  assign pad_l       = snap_q[2];
  assign pad_r       = snap_q[3];
  assign frame_valid = frame_valid_q;
  assign busy        = (state_q != StIdle);
  assign overrun     = overrun_q;

endmodule
